nxn_game_controller: RTL and testbench
======================================

// Module: nxn_game_controller
// PURPOSE
//  Parametrised N x N tic-tac-toe controller: game FSM, internal board storage,
//  win/draw detection, per-player score counters and click-release handshake.
//  Sits between click decoder (cell_click) and VGA renderer (board_x/board_o, flags).
//  Replaces fixed 3x3 game FSM + external position registers with one sequential block.
// PARAMETERS
//  N          3   board side; N*N cells, win = N in a row (row, column, either diagonal)
//  SCORE_W    4   score counter width; counters saturate at 2**SCORE_W-1
//  TIMEOUT    500_000_000  cycles allowed per turn (used only with MOVE_TIMEOUT_EN)
// PORTS
//  clk_100MHz   in   1        system clock, all state on rising edge
//  rst          in   1        asynchronous, active-high reset
//  cell_click   in   N*N      level click per cell; lowest set index wins if several
//  new_game     in   1        level; leaves result screen / restarts game
//  clear_score  in   1        level; zeroes both scores (any state)
//  board_x      out  N*N      cells owned by X
//  board_o      out  N*N      cells owned by O
//  turn_x       out  1        1 = X to move
//  score_x      out  SCORE_W  X wins
//  score_o      out  SCORE_W  O wins
//  win_x/win_o  out  1        held high in WIN_X / WIN_O
//  draw         out  1        held high in DRAW
//  illegal      out  1        1-cycle pulse: click on occupied cell
//  state        out  3        FSM state code for debug LEDs
// BEHAVIOUR
//  Reset: board_x=board_o=0, turn_x=1, scores=0, flags=0, illegal=0, state=IDLE(0).
//  States: IDLE0 TURN1 PLACE2 CHECK3 RELEASE4 WIN_X5 WIN_O6 DRAW7.
//  IDLE: boards cleared, turn_x=1; any click -> RELEASE (click not placed).
//  RELEASE: wait until cell_click==0, then -> TURN. Each click places at most once.
//  TURN: lowest set index i: cell free -> latch i, PLACE; occupied -> illegal pulse,
//        RELEASE (turn unchanged). No click: stay. new_game in TURN -> IDLE.
//  PLACE (1 cycle): set bit i in board of current player.
//  CHECK (1 cycle): win for mover -> WIN_X/WIN_O, score +1 (saturating) once on entry;
//        else board full -> DRAW; else toggle turn_x, -> RELEASE.
//  Latency: click sampled cycle t -> board bit visible t+2, result state t+3.
//  WIN_*/DRAW: board frozen; new_game -> IDLE (boards clear next cycle). X always
//        opens a new game.
//  clear_score: scores=0 next cycle; if coincident with win increment, clear wins.
//  Win logic combinational over registered boards: N rows, N cols, 2 diagonals.
//  Draw only if full AND no win (win has priority on last cell).
//  Illegal state codes: -> IDLE next cycle. rst mid-game: immediate return to reset values.
// CONFIGURATION
//  MOVE_TIMEOUT_EN defined: counter loads on TURN entry; after TIMEOUT cycles in
//    TURN without valid placement, turn_x toggles, counter reloads, no cell placed.
//    Counter frozen in RELEASE (not reset). Illegal click does not reload.
//  MOVE_TIMEOUT_EN undefined: no counter; TURN waits indefinitely; TIMEOUT ignored.
// TESTING
//  rst mid-PLACE -> all outputs at reset values same cycle, state=0.
//  N=3: X 0,O 3,X 1,O 4,X 2 (release between) -> win_x=1, score_x=1, board_x=0x007.
//  N=3 fill X{0,1,5,6,8} O{2,3,4,7} -> draw=1, scores unchanged.
//  Click occupied cell 4 on O turn -> illegal 1 cycle, turn_x=0, boards unchanged.
//  score_x=15 (SCORE_W=4), X wins again -> stays 15; clear_score -> 0 next cycle.
//  MOVE_TIMEOUT_EN, TIMEOUT=8: no click 8 cycles in TURN -> turn_x 1->0, boards same.

Source files
------------

// File: rtl/nxn_game_controller_if.sv
// Signal bundle between click decoder / VGA renderer (master) and the
// N x N game controller (slave).
interface nxn_game_controller_if #(
    parameter int N       = 3,
    parameter int SCORE_W = 4
);
    logic [N*N-1:0]     cell_click;
    logic               new_game;
    logic               clear_score;
    logic [N*N-1:0]     board_x;
    logic [N*N-1:0]     board_o;
    logic               turn_x;
    logic [SCORE_W-1:0] score_x;
    logic [SCORE_W-1:0] score_o;
    logic               win_x;
    logic               win_o;
    logic               draw;
    logic               illegal;
    logic [2:0]         state;

    modport master (
        output cell_click, new_game, clear_score,
        input  board_x, board_o, turn_x, score_x, score_o,
               win_x, win_o, draw, illegal, state
    );

    modport slave (
        input  cell_click, new_game, clear_score,
        output board_x, board_o, turn_x, score_x, score_o,
               win_x, win_o, draw, illegal, state
    );
endinterface

// File: rtl/nxn_game_controller.sv
// N x N tic-tac-toe controller: game FSM, board storage, win/draw detection, scores.
// Optional per-turn timeout enabled by defining MOVE_TIMEOUT_EN.
module nxn_game_controller #(
    parameter int N       = 3,
    parameter int SCORE_W = 4,
    parameter int TIMEOUT = 500_000_000
) (
    input  logic                 clk_100MHz,
    input  logic                 rst,
    nxn_game_controller_if.slave bus
);
    localparam int CELLS = N * N;
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TURN    = 3'd1,
        S_PLACE   = 3'd2,
        S_CHECK   = 3'd3,
        S_RELEASE = 3'd4,
        S_WIN_X   = 3'd5,
        S_WIN_O   = 3'd6,
        S_DRAW    = 3'd7
    } state_t;

    state_t             r_state;
    logic [CELLS-1:0]   r_board_x;
    logic [CELLS-1:0]   r_board_o;
    logic               r_turn_x;
    logic [SCORE_W-1:0] r_score_x;
    logic [SCORE_W-1:0] r_score_o;
    logic               r_win_x;
    logic               r_win_o;
    logic               r_draw;
    logic               r_illegal;
    logic [IDX_W-1:0]   r_idx;

`ifdef MOVE_TIMEOUT_EN
    localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
    logic [TMR_W-1:0]            r_timer;
`endif

    logic             w_any;
    logic [IDX_W-1:0] w_idx;
    logic             w_occupied;
    logic [CELLS-1:0] w_mover;
    logic             w_row;
    logic             w_col;
    logic             w_d1;
    logic             w_d2;
    logic             w_win;
    logic             w_full;

    // Lowest set click index wins when several cells are pressed.
    always_comb begin : click_pick
        w_any = 1'b0;
        w_idx = '0;
        for (int unsigned i = 0; i < CELLS; i++) begin
            if (bus.cell_click[i] && !w_any) begin
                w_idx = IDX_W'(i);
                w_any = 1'b1;
            end
        end
        w_occupied = r_board_x[w_idx] | r_board_o[w_idx];
    end

    // Only the player who just moved can have completed a line.
    always_comb begin : win_detect
        w_mover = r_turn_x ? r_board_x : r_board_o;
        w_win   = 1'b0;
        w_row   = 1'b1;
        w_col   = 1'b1;
        w_d1    = 1'b1;
        w_d2    = 1'b1;
        for (int unsigned r = 0; r < N; r++) begin
            w_row = 1'b1;
            w_col = 1'b1;
            for (int unsigned c = 0; c < N; c++) begin
                w_row = w_row & w_mover[r*N + c];
                w_col = w_col & w_mover[c*N + r];
            end
            w_d1  = w_d1 & w_mover[r*N + r];
            w_d2  = w_d2 & w_mover[r*N + (N - 1 - r)];
            w_win = w_win | w_row | w_col;
        end
        w_win  = w_win | w_d1 | w_d2;
        w_full = &(r_board_x | r_board_o);
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_board_x <= '0;
            r_board_o <= '0;
            r_turn_x  <= 1'b1;
            r_score_x <= '0;
            r_score_o <= '0;
            r_win_x   <= 1'b0;
            r_win_o   <= 1'b0;
            r_draw    <= 1'b0;
            r_illegal <= 1'b0;
            r_idx     <= '0;
`ifdef MOVE_TIMEOUT_EN
            r_timer   <= TMR_LOAD;
`endif
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_board_x <= '0;
                    r_board_o <= '0;
                    r_turn_x  <= 1'b1;
`ifdef MOVE_TIMEOUT_EN
                    r_timer   <= TMR_LOAD;
`endif
                    if (w_any) r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (!w_any) r_state <= S_TURN;
                end
                S_TURN: begin
                    if (bus.new_game) begin
                        r_board_x <= '0;
                        r_board_o <= '0;
                        r_turn_x  <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (w_any) begin
                        if (w_occupied) begin
                            r_illegal <= 1'b1;
                            r_state   <= S_RELEASE;
                        end else begin
                            r_idx   <= w_idx;
                            r_state <= S_PLACE;
                        end
                    end else begin
`ifdef MOVE_TIMEOUT_EN
                        if (r_timer == '0) begin
                            r_turn_x <= ~r_turn_x;
                            r_timer  <= TMR_LOAD;
                        end else begin
                            r_timer  <= r_timer - 1'b1;
                        end
`endif
                    end
                end
                S_PLACE: begin
                    if (r_turn_x) r_board_x[r_idx] <= 1'b1;
                    else          r_board_o[r_idx] <= 1'b1;
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (w_win) begin
                        if (r_turn_x) begin
                            r_win_x <= 1'b1;
                            r_state <= S_WIN_X;
                            if (r_score_x != '1) r_score_x <= r_score_x + 1'b1;
                        end else begin
                            r_win_o <= 1'b1;
                            r_state <= S_WIN_O;
                            if (r_score_o != '1) r_score_o <= r_score_o + 1'b1;
                        end
                    end else if (w_full) begin
                        r_draw  <= 1'b1;
                        r_state <= S_DRAW;
                    end else begin
                        r_turn_x <= ~r_turn_x;
                        r_state  <= S_RELEASE;
`ifdef MOVE_TIMEOUT_EN
                        r_timer  <= TMR_LOAD;
`endif
                    end
                end
                S_WIN_X, S_WIN_O, S_DRAW: begin
                    if (bus.new_game) begin
                        r_board_x <= '0;
                        r_board_o <= '0;
                        r_turn_x  <= 1'b1;
                        r_win_x   <= 1'b0;
                        r_win_o   <= 1'b0;
                        r_draw    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_win_x <= 1'b0;
                    r_win_o <= 1'b0;
                    r_draw  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
            // Placed after the FSM so a clear overrides a coincident win increment.
            if (bus.clear_score) begin
                r_score_x <= '0;
                r_score_o <= '0;
            end
        end
    end

    assign bus.board_x = r_board_x;
    assign bus.board_o = r_board_o;
    assign bus.turn_x  = r_turn_x;
    assign bus.score_x = r_score_x;
    assign bus.score_o = r_score_o;
    assign bus.win_x   = r_win_x;
    assign bus.win_o   = r_win_o;
    assign bus.draw    = r_draw;
    assign bus.illegal = r_illegal;
    assign bus.state   = r_state;
endmodule

// File: tb/tb_nxn_game_controller.sv
// Self-checking bench for nxn_game_controller: directed games plus random play
// checked against a move-level board model.
`timescale 1ns/1ps
module tb_nxn_game_controller;
    localparam int N    = 3;
    localparam int SW   = 4;
    localparam int NN   = N * N;
    localparam int SMAX = (1 << SW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nxn_game_controller_if #(.N(N), .SCORE_W(SW)) bus ();

    nxn_game_controller #(.N(N), .SCORE_W(SW), .TIMEOUT(8)) dut (
        .clk_100MHz (clk),
        .rst        (rst),
        .bus        (bus)
    );

    int tests = 0;
    int fails = 0;

    // Model: owner 0 = empty, 1 = X, 2 = O; m_res 0 = playing, 1 = X won, 2 = O won, 3 = draw
    int owner [NN];
    bit m_turn_x;
    int m_sx, m_so, m_res;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NN-1:0] m_board(input int p);
        logic [NN-1:0] b;
        b = '0;
        for (int i = 0; i < NN; i++) if (owner[i] == p) b[i] = 1'b1;
        return b;
    endfunction

    function automatic bit m_win(input int p);
        bit d1, d2, rw, cl;
        d1 = 1'b1;
        d2 = 1'b1;
        for (int r = 0; r < N; r++) begin
            rw = 1'b1;
            cl = 1'b1;
            for (int c = 0; c < N; c++) begin
                if (owner[r*N + c] != p) rw = 1'b0;
                if (owner[c*N + r] != p) cl = 1'b0;
            end
            if (rw || cl) return 1'b1;
            if (owner[r*N + r] != p) d1 = 1'b0;
            if (owner[r*N + N - 1 - r] != p) d2 = 1'b0;
        end
        return d1 || d2;
    endfunction

    function automatic bit m_full();
        for (int i = 0; i < NN; i++) if (owner[i] == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_clear_board();
        for (int i = 0; i < NN; i++) owner[i] = 0;
        m_turn_x = 1'b1;
        m_res    = 0;
    endtask

    task automatic check_all(input string tag, input int st);
        chk({tag, ".board_x"}, 32'(bus.board_x), 32'(m_board(1)));
        chk({tag, ".board_o"}, 32'(bus.board_o), 32'(m_board(2)));
        chk({tag, ".turn_x"},  32'(bus.turn_x),  32'(m_turn_x));
        chk({tag, ".score_x"}, 32'(bus.score_x), 32'(m_sx));
        chk({tag, ".score_o"}, 32'(bus.score_o), 32'(m_so));
        chk({tag, ".win_x"},   32'(bus.win_x),   32'(m_res == 1));
        chk({tag, ".win_o"},   32'(bus.win_o),   32'(m_res == 2));
        chk({tag, ".draw"},    32'(bus.draw),    32'(m_res == 3));
        chk({tag, ".state"},   32'(bus.state),   32'(st));
    endtask

    // Called at a negedge with the DUT in IDLE; leaves it in TURN.
    task automatic start_game();
        bus.cell_click = NN'($urandom_range(1, (1 << NN) - 1));
        @(negedge clk);
        check_all("start", 4);
        bus.cell_click = '0;
        @(negedge clk);
        check_all("turn", 1);
    endtask

    // Called at a negedge with the DUT in TURN.
    task automatic move(input logic [NN-1:0] vec, input bit clr);
        int idx;
        idx = 0;
        for (int i = NN - 1; i >= 0; i--) if (vec[i]) idx = i;
        bus.cell_click = vec;
        @(negedge clk);
        if (owner[idx] != 0) begin
            chk("illegal.pulse", 32'(bus.illegal), 32'd1);
            check_all("illegal", 4);
            @(negedge clk);
            chk("illegal.drop", 32'(bus.illegal), 32'd0);
            bus.cell_click = '0;
            @(negedge clk);
            check_all("illegal.ret", 1);
            return;
        end
        chk("place.state", 32'(bus.state), 32'd2);
        chk("place.illegal", 32'(bus.illegal), 32'd0);
        @(negedge clk);
        owner[idx] = m_turn_x ? 1 : 2;
        check_all("check", 3);
        if (clr) bus.clear_score = 1'b1;
        @(negedge clk);
        bus.clear_score = 1'b0;
        if (m_win(owner[idx])) begin
            m_res = m_turn_x ? 1 : 2;
            if (m_turn_x) m_sx = (m_sx < SMAX) ? m_sx + 1 : SMAX;
            else          m_so = (m_so < SMAX) ? m_so + 1 : SMAX;
        end else if (m_full()) begin
            m_res = 3;
        end else begin
            m_turn_x = !m_turn_x;
        end
        if (clr) begin
            m_sx = 0;
            m_so = 0;
        end
        check_all("result", (m_res == 0) ? 4 : m_res + 4);
        bus.cell_click = '0;
        if (m_res == 0) begin
            @(negedge clk);
            check_all("next", 1);
        end
    endtask

    task automatic do_new_game();
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
        m_clear_board();
        check_all("newgame", 0);
    endtask

    task automatic do_clear(input int st);
        bus.clear_score = 1'b1;
        @(negedge clk);
        bus.clear_score = 1'b0;
        m_sx = 0;
        m_so = 0;
        check_all("clear", st);
    endtask

    task automatic x_wins_row0(input bit clr_last);
        move(NN'(1 << 0), 1'b0);
        move(NN'(1 << 3), 1'b0);
        move(NN'(1 << 1), 1'b0);
        move(NN'(1 << 4), 1'b0);
        move(NN'(1 << 2), clr_last);
    endtask

    initial begin
        int free [$];
        int idx, moves;
        logic [NN-1:0] vec, extra;

        rst             = 1'b1;
        bus.cell_click  = '0;
        bus.new_game    = 1'b0;
        bus.clear_score = 1'b0;
        m_clear_board();
        m_sx = 0;
        m_so = 0;
        @(negedge clk);
        @(negedge clk);
        check_all("reset", 0);
        chk("reset.illegal", 32'(bus.illegal), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_all("idle", 0);

        // X 0, O 3, X 1, O 4, X 2 -> X wins on the top row
        start_game();
        x_wins_row0(1'b0);
        chk("xwin.board_x", 32'(bus.board_x), 32'h007);
        chk("xwin.score_x", 32'(bus.score_x), 32'd1);

        // O clicks cell 4 already held by X
        do_new_game();
        start_game();
        move(NN'(1 << 4), 1'b0);
        move(NN'(1 << 4), 1'b0);
        chk("illegal.turn_x", 32'(bus.turn_x), 32'd0);
        do_new_game();

        // Draw: X{0,1,5,6,8} O{2,3,4,7}
        start_game();
        move(NN'(1 << 0), 1'b0);
        move(NN'(1 << 2), 1'b0);
        move(NN'(1 << 1), 1'b0);
        move(NN'(1 << 3), 1'b0);
        move(NN'(1 << 5), 1'b0);
        move(NN'(1 << 4), 1'b0);
        move(NN'(1 << 6), 1'b0);
        move(NN'(1 << 7), 1'b0);
        move(NN'(1 << 8), 1'b0);
        chk("draw.flag", 32'(bus.draw), 32'd1);
        chk("draw.score_x", 32'(bus.score_x), 32'd1);
        do_new_game();

        // Saturation of score_x
        repeat (16) begin
            start_game();
            x_wins_row0(1'b0);
            do_new_game();
        end
        chk("sat.score_x", 32'(bus.score_x), 32'(SMAX));
        do_clear(0);

        // clear_score coincident with a winning increment
        start_game();
        move(NN'(1 << 2), 1'b0);
        do_clear(1);
        do_new_game();
        start_game();
        x_wins_row0(1'b1);
        chk("clrwin.score_x", 32'(bus.score_x), 32'd0);
        do_new_game();

        // Asynchronous reset while in PLACE
        start_game();
        bus.cell_click = NN'(1 << 5);
        @(negedge clk);
        chk("rstplace.state", 32'(bus.state), 32'd2);
        #1 rst = 1'b1;
        #1;
        m_clear_board();
        m_sx = 0;
        m_so = 0;
        check_all("rstplace", 0);
        chk("rstplace.illegal", 32'(bus.illegal), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.cell_click = '0;
        @(negedge clk);

`ifdef MOVE_TIMEOUT_EN
        start_game();
        repeat (7) @(negedge clk);
        chk("tmo.before", 32'(bus.turn_x), 32'd1);
        @(negedge clk);
        m_turn_x = 1'b0;
        check_all("tmo.after", 1);
        do_new_game();
`endif

        // Random play
        repeat (25) begin
            start_game();
            moves = 0;
            while (m_res == 0 && moves < 40) begin
                moves++;
                if ($urandom_range(0, 19) == 0) begin
                    do_new_game();
                    break;
                end
                if ($urandom_range(0, 9) == 0) do_clear(1);
                if ($urandom_range(0, 5) == 0) begin
                    idx = $urandom_range(0, NN - 1);
                end else begin
                    free.delete();
                    for (int i = 0; i < NN; i++) if (owner[i] == 0) free.push_back(i);
                    idx = free[$urandom_range(0, free.size() - 1)];
                end
                vec   = NN'(1 << idx);
                extra = NN'($urandom);
                for (int j = idx + 1; j < NN; j++) vec[j] = extra[j];
                move(vec, $urandom_range(0, 7) == 0);
            end
            if (m_res != 0 || bus.state != 3'd0) do_new_game();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
